// File: rtl/simon_pkg.sv
// simon_pkg
// Shared encodings for the Simon datapath and its controller FSM:
//   - display_choice encodings (LED source select)
//   - playback sequencer state enum
package simon_pkg;

    // display_choice: which source drives pattern_leds
    localparam logic [1:0] DISP_INPUT    = 2'd0;  // live switch input
    localparam logic [1:0] DISP_PLAYBACK = 2'd1;  // stored entry while playing
    localparam logic [1:0] DISP_REPEAT   = 2'd2;  // live switch input during repeat
    localparam logic [1:0] DISP_DONE     = 2'd3;  // all LEDs lit

    typedef enum logic [1:0] {
        PLAY_IDLE = 2'd0,
        PLAY_SHOW = 2'd1,
        PLAY_END  = 2'd2
    } play_state_t;

endpackage

// File: rtl/simon_pattern_mem.sv
// simon_pattern_mem
// DEPTH x WIDTH flop array holding the player-entered sequence.
// Synchronous write port, combinational read port, contents not reset.
// Ports:
//   clk_i      clock
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_addr_i  read address
//   rd_data_o  read data (combinational)
module simon_pattern_mem
    import simon_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/simon_seq_datapath.sv
// simon_seq_datapath
// Simon-game datapath: pattern storage, validity check against the latched
// difficulty level, repeat-phase comparison, LED drive and an autonomous
// playback sequencer that shows each stored entry for HOLD cycles.
// Optional feature macro: SIMON_DP_SCORE_EN adds best_score_o, the highest
// count seen since reset (survives seq_clear).
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   level_i/level_enable_i  difficulty (0 easy, 1 hard) and its load strobe
//   pattern_i               player switches
//   write_enable_i          append pattern_i to memory
//   seq_clear_i             clear count and current index
//   current_rst_i           clear current index
//   current_enable_i        advance current index (wraps at count-1)
//   display_choice_i        LED source select (simon_pkg DISP_*)
//   play_start_i            start playback pulse
//   pattern_leds_o          LED drive
//   pattern_valid_o         pattern legal at latched level
//   pattern_same_o          pattern matches mem[current]
//   seen_all_o              current is the last stored entry
//   mem_full_o              count == DEPTH
//   playing_o, play_done_o  sequencer active / end-of-playback pulse
//   count_o                 number of stored entries
//
// state     | meaning
// PLAY_IDLE | controller owns current index and writes
// PLAY_SHOW | showing mem[current], hold counts cycles per entry
// PLAY_END  | one-cycle play_done, rewind current to 0
module simon_seq_datapath
    import simon_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 64,
    parameter  int HOLD  = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             level_i,
    input  logic             level_enable_i,
    input  logic [WIDTH-1:0] pattern_i,
    input  logic             write_enable_i,
    input  logic             seq_clear_i,
    input  logic             current_rst_i,
    input  logic             current_enable_i,
    input  logic [1:0]       display_choice_i,
    input  logic             play_start_i,
    output logic [WIDTH-1:0] pattern_leds_o,
    output logic             pattern_valid_o,
    output logic             pattern_same_o,
    output logic             seen_all_o,
    output logic             mem_full_o,
    output logic             playing_o,
    output logic             play_done_o,
`ifdef SIMON_DP_SCORE_EN
    output logic [CW-1:0]    best_score_o,
`endif
    output logic [CW-1:0]    count_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    play_state_t      state_q;
    logic             level_q;
    logic [CW-1:0]    count_q;
    logic [IW-1:0]    current_q;
    logic [HW-1:0]    hold_q;
    logic             playing_q;
    logic             play_done_q;

    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]    cur_ext;
    logic             at_last;
    logic [IW-1:0]    cur_next;
    logic             wr_ok;

    assign cur_ext  = CW'(current_q);
    assign at_last  = (count_q != '0) && (cur_ext == count_q - CW'(1));
    assign cur_next = at_last ? '0 : current_q + IW'(1);

    assign pattern_valid_o = level_q ? (|pattern_i) : ($countones(pattern_i) == 1);
    assign mem_full_o      = (count_q == DEPTH_C);
    assign pattern_same_o  = (pattern_i == rd_data) && (count_q != '0);
    assign seen_all_o      = at_last;
    assign playing_o       = playing_q;
    assign play_done_o     = play_done_q;
    assign count_o         = count_q;

    // seq_clear wins over a same-cycle write, so nothing lands in memory
    assign wr_ok = write_enable_i & pattern_valid_o & ~mem_full_o
                   & ~playing_q & ~seq_clear_i;

    simon_pattern_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_en_i   (wr_ok),
        .wr_addr_i (count_q[IW-1:0]),
        .wr_data_i (pattern_i),
        .rd_addr_i (current_q),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q <= 1'b0;
        end else if (level_enable_i) begin
            level_q <= level_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= PLAY_IDLE;
            count_q     <= '0;
            current_q   <= '0;
            hold_q      <= '0;
            playing_q   <= 1'b0;
            play_done_q <= 1'b0;
        end else begin
            play_done_q <= 1'b0;
            if (seq_clear_i) begin
                // also aborts playback silently
                state_q   <= PLAY_IDLE;
                count_q   <= '0;
                current_q <= '0;
                hold_q    <= '0;
                playing_q <= 1'b0;
            end else begin
                case (state_q)
                    PLAY_IDLE: begin
                        if (wr_ok) begin
                            count_q <= count_q + CW'(1);
                        end
                        if (play_start_i) begin
                            if (count_q != '0) begin
                                state_q   <= PLAY_SHOW;
                                playing_q <= 1'b1;
                                current_q <= '0;
                                hold_q    <= '0;
                            end else begin
                                state_q     <= PLAY_END;
                                play_done_q <= 1'b1;
                            end
                        end else if (current_rst_i) begin
                            current_q <= '0;
                        end else if (current_enable_i) begin
                            current_q <= (count_q == '0) ? '0 : cur_next;
                        end
                    end
                    PLAY_SHOW: begin
                        if (hold_q == HOLD_LAST) begin
                            hold_q <= '0;
                            if (at_last) begin
                                state_q     <= PLAY_END;
                                playing_q   <= 1'b0;
                                play_done_q <= 1'b1;
                            end else begin
                                current_q <= cur_next;
                            end
                        end else begin
                            hold_q <= hold_q + HW'(1);
                        end
                    end
                    PLAY_END: begin
                        // playing is already low here, so a write may land
                        if (wr_ok) begin
                            count_q <= count_q + CW'(1);
                        end
                        current_q <= '0;
                        hold_q    <= '0;
                        state_q   <= PLAY_IDLE;
                    end
                    default: begin
                        state_q <= PLAY_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        pattern_leds_o = pattern_i;
        case (display_choice_i)
            DISP_INPUT:    pattern_leds_o = pattern_i;
            DISP_PLAYBACK: pattern_leds_o = playing_q ? rd_data : '0;
            DISP_REPEAT:   pattern_leds_o = pattern_i;
            DISP_DONE:     pattern_leds_o = '1;
            default:       pattern_leds_o = pattern_i;
        endcase
    end

`ifdef SIMON_DP_SCORE_EN
    logic [CW-1:0] best_score_q;
    logic [CW-1:0] best_score_d;

    assign best_score_d = (count_q > best_score_q) ? count_q : best_score_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            best_score_q <= '0;
        end else begin
            best_score_q <= best_score_d;
        end
    end

    assign best_score_o = best_score_q;
`endif

endmodule

// File: tb/tb_simon_seq_datapath.sv
module tb_simon_seq_datapath;
    import simon_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int HOLD  = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             level;
    logic             level_enable;
    logic [WIDTH-1:0] pattern;
    logic             write_enable;
    logic             seq_clear;
    logic             current_rst;
    logic             current_enable;
    logic [1:0]       display_choice;
    logic             play_start;
    logic [WIDTH-1:0] pattern_leds;
    logic             pattern_valid;
    logic             pattern_same;
    logic             seen_all;
    logic             mem_full;
    logic             playing;
    logic             play_done;
    logic [CW-1:0]    count;
`ifdef SIMON_DP_SCORE_EN
    logic [CW-1:0]    best_score;
`endif

    simon_seq_datapath #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .HOLD  (HOLD)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .level_i          (level),
        .level_enable_i   (level_enable),
        .pattern_i        (pattern),
        .write_enable_i   (write_enable),
        .seq_clear_i      (seq_clear),
        .current_rst_i    (current_rst),
        .current_enable_i (current_enable),
        .display_choice_i (display_choice),
        .play_start_i     (play_start),
        .pattern_leds_o   (pattern_leds),
        .pattern_valid_o  (pattern_valid),
        .pattern_same_o   (pattern_same),
        .seen_all_o       (seen_all),
        .mem_full_o       (mem_full),
        .playing_o        (playing),
        .play_done_o      (play_done),
`ifdef SIMON_DP_SCORE_EN
        .best_score_o     (best_score),
`endif
        .count_o          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, lvl, len;
        logic [3:0] pat;
        logic       we, sc, cr, ce;
        logic [1:0] disp;
        logic       ps;
    } in_t;

    typedef struct {
        logic [3:0] leds;
        logic       valid, same, seen, full, play, done;
        logic [3:0] cnt;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[$];

    function automatic vec_t v(
        input logic r, lvl, len, input logic [3:0] pat,
        input logic we, sc, cr, ce, input logic [1:0] d, input logic ps,
        input logic [3:0] leds, input logic valid, same, seen, full, play, done,
        input logic [3:0] cnt);
        vec_t x;
        x.i.rst = r;  x.i.lvl = lvl; x.i.len = len; x.i.pat = pat;
        x.i.we = we;  x.i.sc = sc;   x.i.cr = cr;   x.i.ce = ce;
        x.i.disp = d; x.i.ps = ps;
        x.e.leds = leds; x.e.valid = valid; x.e.same = same; x.e.seen = seen;
        x.e.full = full; x.e.play = play;   x.e.done = done; x.e.cnt = cnt;
        return x;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", n, act, req);
        end
    endtask

    // Called at posedge+1: drive, queue expectation, compare at negedge,
    // return at the following posedge+1.
    task automatic run(input vec_t x, input string tag);
        exp_t e;
        rst            = x.i.rst;
        level          = x.i.lvl;
        level_enable   = x.i.len;
        pattern        = x.i.pat;
        write_enable   = x.i.we;
        seq_clear      = x.i.sc;
        current_rst    = x.i.cr;
        current_enable = x.i.ce;
        display_choice = x.i.disp;
        play_start     = x.i.ps;
        sb.push_back(x.e);
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, ".leds"},  32'(pattern_leds),  32'(e.leds));
        chk({tag, ".valid"}, 32'(pattern_valid), 32'(e.valid));
        chk({tag, ".same"},  32'(pattern_same),  32'(e.same));
        chk({tag, ".seen"},  32'(seen_all),      32'(e.seen));
        chk({tag, ".full"},  32'(mem_full),      32'(e.full));
        chk({tag, ".play"},  32'(playing),       32'(e.play));
        chk({tag, ".done"},  32'(play_done),     32'(e.done));
        chk({tag, ".count"}, 32'(count),         32'(e.cnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] pb_mem [3];
        pb_mem[0] = 4'b0001; pb_mem[1] = 4'b0010; pb_mem[2] = 4'b0100;

        rst = 1'b1; level = 0; level_enable = 0; pattern = '0; write_enable = 0;
        seq_clear = 0; current_rst = 0; current_enable = 0; display_choice = DISP_INPUT;
        play_start = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        //        r l e pat     we sc cr ce disp ps | leds   vl sm se fu pl dn cnt
        tbl.push_back(v(0,0,0,4'b0000,0,0,0,0,2'd0,0, 4'h0,0,0,0,0,0,0,4'd0));
        tbl.push_back(v(0,0,0,4'b0010,1,0,0,0,2'd0,0, 4'h2,1,0,0,0,0,0,4'd0));
        tbl.push_back(v(0,0,0,4'b0110,1,0,0,0,2'd0,0, 4'h6,0,0,1,0,0,0,4'd1));
        tbl.push_back(v(0,1,1,4'b0110,0,0,0,0,2'd0,0, 4'h6,0,0,1,0,0,0,4'd1));
        tbl.push_back(v(0,0,0,4'b0110,1,0,0,0,2'd0,0, 4'h6,1,0,1,0,0,0,4'd1));
        tbl.push_back(v(0,0,0,4'b0110,0,0,0,0,2'd3,0, 4'hF,1,0,0,0,0,0,4'd2));
        tbl.push_back(v(0,0,0,4'b1000,1,1,0,0,2'd0,0, 4'h8,1,0,0,0,0,0,4'd2));
        tbl.push_back(v(0,0,1,4'b0010,1,0,0,0,2'd0,0, 4'h2,1,0,0,0,0,0,4'd0));
        tbl.push_back(v(0,0,0,4'b0100,1,0,0,0,2'd0,0, 4'h4,1,0,1,0,0,0,4'd1));
        tbl.push_back(v(0,0,0,4'b0010,0,0,0,0,2'd2,0, 4'h2,1,1,0,0,0,0,4'd2));
        tbl.push_back(v(0,0,0,4'b0010,0,0,0,1,2'd2,0, 4'h2,1,1,0,0,0,0,4'd2));
        tbl.push_back(v(0,0,0,4'b0100,0,0,0,0,2'd2,0, 4'h4,1,1,1,0,0,0,4'd2));
        tbl.push_back(v(0,0,0,4'b0100,0,0,0,1,2'd2,0, 4'h4,1,1,1,0,0,0,4'd2));
        tbl.push_back(v(0,0,0,4'b0010,0,0,0,0,2'd2,0, 4'h2,1,1,0,0,0,0,4'd2));
        tbl.push_back(v(0,0,0,4'b0010,0,0,0,1,2'd2,0, 4'h2,1,1,0,0,0,0,4'd2));
        tbl.push_back(v(0,0,0,4'b0010,0,0,1,1,2'd2,0, 4'h2,1,0,1,0,0,0,4'd2));
        tbl.push_back(v(0,0,0,4'b0010,0,0,0,0,2'd2,0, 4'h2,1,1,0,0,0,0,4'd2));
        tbl.push_back(v(0,0,0,4'b1000,1,0,0,0,2'd0,0, 4'h8,1,0,0,0,0,0,4'd2));
        tbl.push_back(v(0,0,0,4'b0001,1,0,0,0,2'd0,0, 4'h1,1,0,0,0,0,0,4'd3));
        tbl.push_back(v(0,0,0,4'b0010,1,0,0,0,2'd0,0, 4'h2,1,1,0,0,0,0,4'd4));
        tbl.push_back(v(0,0,0,4'b0100,1,0,0,0,2'd0,0, 4'h4,1,0,0,0,0,0,4'd5));
        tbl.push_back(v(0,0,0,4'b1000,1,0,0,0,2'd0,0, 4'h8,1,0,0,0,0,0,4'd6));
        tbl.push_back(v(0,0,0,4'b0001,1,0,0,0,2'd0,0, 4'h1,1,0,0,0,0,0,4'd7));
        tbl.push_back(v(0,0,0,4'b0100,1,0,0,0,2'd0,0, 4'h4,1,0,0,1,0,0,4'd8));
        tbl.push_back(v(0,0,0,4'b0100,0,0,0,0,2'd1,0, 4'h0,1,0,0,1,0,0,4'd8));
        tbl.push_back(v(0,0,0,4'b0100,1,1,0,0,2'd0,0, 4'h4,1,0,0,1,0,0,4'd8));
        tbl.push_back(v(0,0,0,4'b0100,0,0,0,0,2'd0,0, 4'h4,1,0,0,0,0,0,4'd0));
        tbl.push_back(v(0,0,0,4'b0000,0,0,0,1,2'd0,0, 4'h0,0,0,0,0,0,0,4'd0));

        for (int k = 0; k < tbl.size(); k++) begin
            run(tbl[k], $sformatf("vec%0d", k));
        end

        // playback of three entries, HOLD=3, with ignored controls mid-play
        run(v(0,0,0,4'b0001,1,0,0,0,2'd0,0, 4'h1,1,0,0,0,0,0,4'd0), "pbst0");
        run(v(0,0,0,4'b0010,1,0,0,0,2'd0,0, 4'h2,1,0,1,0,0,0,4'd1), "pbst1");
        run(v(0,0,0,4'b0100,1,0,0,0,2'd0,0, 4'h4,1,0,0,0,0,0,4'd2), "pbst2");
        run(v(0,0,0,4'b0000,0,0,0,0,2'd1,1, 4'h0,0,0,0,0,0,0,4'd3), "pbgo");
        for (int c = 1; c <= 9; c++) begin
            int         k;
            logic [3:0] p;
            k = (c - 1) / HOLD;
            p = (c == 2) ? 4'b1000 : 4'b0000;
            run(v(0,0,0,p,(c == 2),0,(c == 4),(c == 3),2'd1,(c == 4),
                  pb_mem[k],(c == 2),0,(k == 2),0,1,0,4'd3),
                $sformatf("pb_t%0d", c));
        end
        run(v(0,0,0,4'b0000,0,0,0,0,2'd1,0, 4'h0,0,0,1,0,0,1,4'd3), "pb_end");
        run(v(0,0,0,4'b0001,0,0,0,0,2'd0,0, 4'h1,1,1,0,0,0,0,4'd3), "pb_after");

        // play_start with empty memory
        run(v(0,0,0,4'b0000,0,1,0,0,2'd0,0, 4'h0,0,0,0,0,0,0,4'd3), "z_clr");
        run(v(0,0,0,4'b0000,0,0,0,0,2'd1,1, 4'h0,0,0,0,0,0,0,4'd0), "z_go");
        run(v(0,0,0,4'b0000,0,0,0,0,2'd1,0, 4'h0,0,0,0,0,0,1,4'd0), "z_done");
        run(v(0,0,0,4'b0000,0,0,0,0,2'd1,0, 4'h0,0,0,0,0,0,0,4'd0), "z_idle");

        // reset asserted mid-playback
        run(v(0,0,0,4'b0001,1,0,0,0,2'd0,0, 4'h1,1,0,0,0,0,0,4'd0), "r_st0");
        run(v(0,0,0,4'b0010,1,0,0,0,2'd0,0, 4'h2,1,0,1,0,0,0,4'd1), "r_st1");
        run(v(0,0,0,4'b0000,0,0,0,0,2'd1,1, 4'h0,0,0,0,0,0,0,4'd2), "r_go");
        run(v(0,0,0,4'b0000,0,0,0,0,2'd1,0, 4'h1,0,0,0,0,1,0,4'd2), "r_t1");
        run(v(0,0,0,4'b0000,0,0,0,0,2'd1,0, 4'h1,0,0,0,0,1,0,4'd2), "r_t2");
        run(v(1,0,0,4'b0000,0,0,0,0,2'd1,0, 4'h0,0,0,0,0,0,0,4'd0), "r_rst");
        for (int c = 0; c < 6; c++) begin
            run(v(0,0,0,4'b0000,0,0,0,0,2'd1,0, 4'h0,0,0,0,0,0,0,4'd0),
                $sformatf("r_post%0d", c));
        end
        run(v(0,0,0,4'b0010,0,0,0,0,2'd0,0, 4'h2,1,0,0,0,0,0,4'd0), "r_lvl");

`ifdef SIMON_DP_SCORE_EN
        for (int k = 0; k < 5; k++) begin
            pattern = 4'b0001 << (k % 4);
            write_enable = 1'b1;
            @(posedge clk);
            #1;
        end
        write_enable = 1'b0;
        seq_clear = 1'b1;
        @(posedge clk);
        #1;
        seq_clear = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pattern = 4'b0010;
            write_enable = 1'b1;
            @(posedge clk);
            #1;
        end
        write_enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("score.count", 32'(count), 32'd2);
        chk("score.best", 32'(best_score), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        chk("score.rst", 32'(best_score), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
